// File: rtl/tia_palette_engine.sv
// Palette lookup engine: maps {hue, lum} pixel indices to RGB through one of
// three fixed console palettes (NTSC, PAL, SECAM) or a writable user bank.
// Two-stage pipeline: stage 1 registers the index and bank, stage 2 registers
// the looked-up color. After reset the user bank is swept to USER_INIT.
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   pixValid, lum, hue    pixel index in
//   blank                 force black for this pixel
//   mode, vsync           requested bank, committed on vsync rising edge
//   wrEn, wrAddr, wrData  user-bank write request (held until wrReady)
//   wrReady               write accepted this cycle when wrEn && wrReady
//   outColor, outValid    registered RGB result, two cycles after pixValid
//   activeMode            bank currently used for new lookups
module tia_palette_engine #(
  parameter int unsigned CHANNEL_BITS = 8,
  parameter int unsigned LUM_BITS = 3,
  parameter logic [3*CHANNEL_BITS-1:0] USER_INIT = '0,
  localparam int unsigned ADDR_W = 4 + LUM_BITS,
  localparam int unsigned OUT_W = 3 * CHANNEL_BITS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pixValid,
  input  logic [3:0]        lum,
  input  logic [3:0]        hue,
  input  logic              blank,
  input  logic [1:0]        mode,
  input  logic              vsync,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [OUT_W-1:0]  wrData,
  output logic              wrReady,
  output logic [OUT_W-1:0]  outColor,
  output logic              outValid,
  output logic [1:0]        activeMode
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  localparam logic [23:0] NTSC_TAB [128] = '{
    24'h000000, 24'h404040, 24'h6c6c6c, 24'h909090, 24'hb0b0b0, 24'hc8c8c8, 24'hdcdcdc, 24'hececec,
    24'h444400, 24'h646410, 24'h848424, 24'ha0a034, 24'hb8b840, 24'hd0d050, 24'he8e85c, 24'hfcfc68,
    24'h702800, 24'h844414, 24'h985c28, 24'hac783c, 24'hbc8c4c, 24'hcc9c5c, 24'hdcb468, 24'hecc878,
    24'h841800, 24'h983418, 24'hac5030, 24'hc06848, 24'hd0805c, 24'he09470, 24'heca880, 24'hfcbc94,
    24'h880000, 24'h9c2020, 24'hb03c3c, 24'hc05858, 24'hd07070, 24'he08888, 24'heca0a0, 24'hfcb4b4,
    24'h78005c, 24'h8c2074, 24'ha03c88, 24'hb0589c, 24'hc070b0, 24'hd084c0, 24'hdc9cd0, 24'hecb0e0,
    24'h480078, 24'h602090, 24'h783ca4, 24'h8c58b8, 24'ha070cc, 24'hb484dc, 24'hc49cec, 24'hd4b0fc,
    24'h140084, 24'h302098, 24'h4c3cac, 24'h6858c0, 24'h7c70d0, 24'h9488e0, 24'ha8a0ec, 24'hbcb4fc,
    24'h000088, 24'h1c209c, 24'h3840b0, 24'h505cc0, 24'h6874d0, 24'h7c8ce0, 24'h90a4ec, 24'ha4b8fc,
    24'h00187c, 24'h1c3890, 24'h3854a8, 24'h5070bc, 24'h6888cc, 24'h7c9cdc, 24'h90b4ec, 24'ha4c8fc,
    24'h002c5c, 24'h1c4c78, 24'h386890, 24'h5084ac, 24'h689cc0, 24'h7cb4d4, 24'h90cce8, 24'ha4e0fc,
    24'h003c2c, 24'h1c5c48, 24'h387c64, 24'h509c80, 24'h68b494, 24'h7cd0ac, 24'h90e4c0, 24'ha4fcd4,
    24'h003c00, 24'h205c20, 24'h407c40, 24'h5c9c5c, 24'h74b474, 24'h8cd08c, 24'ha4e4a4, 24'hb8fcb8,
    24'h143800, 24'h345c1c, 24'h507c38, 24'h6c9850, 24'h84b468, 24'h9ccc7c, 24'hb4e490, 24'hc8fca4,
    24'h2c3000, 24'h4c501c, 24'h687034, 24'h848c4c, 24'h9ca864, 24'hb4c078, 24'hccd488, 24'he0ec9c,
    24'h442800, 24'h644818, 24'h846830, 24'ha08444, 24'hb89c58, 24'hd0b46c, 24'he8cc7c, 24'hfce08c
  };

  localparam logic [23:0] PAL_TAB [128] = '{
    24'h000000, 24'h282828, 24'h505050, 24'h747474, 24'h949494, 24'hb4b4b4, 24'hd0d0d0, 24'hececec,
    24'h000000, 24'h282828, 24'h505050, 24'h747474, 24'h949494, 24'hb4b4b4, 24'hd0d0d0, 24'hececec,
    24'h805800, 24'h947020, 24'ha8843c, 24'hbc9c58, 24'hccac70, 24'hdcc084, 24'hecd09c, 24'hfce0b0,
    24'h445c00, 24'h5c7820, 24'h74903c, 24'h8cac58, 24'ha0c070, 24'hb0d484, 24'hc4e89c, 24'hd4fcb0,
    24'h703400, 24'h885020, 24'ha0683c, 24'hb48458, 24'hc89870, 24'hdcac84, 24'hecc09c, 24'hfcd4b0,
    24'h006414, 24'h208034, 24'h3c9850, 24'h58b06c, 24'h70c484, 24'h84d89c, 24'h9ce8b4, 24'hb0fcc8,
    24'h700014, 24'h882034, 24'ha03c50, 24'hb4586c, 24'hc87084, 24'hdc849c, 24'hec9cb4, 24'hfcb0c8,
    24'h005c5c, 24'h207474, 24'h3c8c8c, 24'h58a4a4, 24'h70b8b8, 24'h84c8c8, 24'h9cdcdc, 24'hb0ecec,
    24'h70005c, 24'h842074, 24'h943c88, 24'ha8589c, 24'hb470b0, 24'hc484c0, 24'hd09cd0, 24'he0b0e0,
    24'h003c70, 24'h1c5888, 24'h3874a0, 24'h508cb4, 24'h68a4c8, 24'h7cb8dc, 24'h90ccec, 24'ha4e0fc,
    24'h580070, 24'h6c2088, 24'h803ca0, 24'h9458b4, 24'ha470c8, 24'hb484dc, 24'hc49cec, 24'hd4b0fc,
    24'h002070, 24'h1c3c88, 24'h3858a0, 24'h5074b4, 24'h6888c8, 24'h7ca0dc, 24'h90b4ec, 24'ha4c8fc,
    24'h3c0080, 24'h542094, 24'h6c3ca8, 24'h8058bc, 24'h9470cc, 24'ha884dc, 24'hb89cec, 24'hc8b0fc,
    24'h000088, 24'h20209c, 24'h3c3cb0, 24'h5858c0, 24'h7070d0, 24'h8888e0, 24'ha0a0ec, 24'hb4b4fc,
    24'h000000, 24'h282828, 24'h505050, 24'h747474, 24'h949494, 24'hb4b4b4, 24'hd0d0d0, 24'hececec,
    24'h000000, 24'h282828, 24'h505050, 24'h747474, 24'h949494, 24'hb4b4b4, 24'hd0d0d0, 24'hececec
  };

  // SECAM has no hue: the same eight colors repeat on every hue row.
  localparam logic [23:0] SECAM_TAB [8] = '{
    24'h000000, 24'h2121ff, 24'hf03c79, 24'hff50ff, 24'h7fff00, 24'h7fffff, 24'hffff3f, 24'hffffff
  };

  // Resize each 8-bit channel: MSBs when narrower, repeated bit pattern when wider.
  function automatic logic [OUT_W-1:0] scale_rgb(input logic [23:0] c);
    logic [OUT_W-1:0] r;
    r = '0;
    for (int unsigned ch = 0; ch < 3; ch++) begin
      for (int unsigned i = 0; i < CHANNEL_BITS; i++) begin
        r[ch*CHANNEL_BITS + (CHANNEL_BITS - 1 - i)] = c[ch*8 + 7 - (i % 8)];
      end
    end
    return r;
  endfunction

  typedef enum logic [0:0] {CLEAR, IDLE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [ADDR_W-1:0]  clr_addr;
  logic               vsync_q;
  logic               s1_valid;
  logic               s1_blank;
  logic [1:0]         s1_bank;
  logic [6:0]         s1_cidx;
  logic [ADDR_W-1:0]  s1_addr;
  logic               ram_we;
  logic [ADDR_W-1:0]  ram_waddr;
  logic [OUT_W-1:0]   ram_wdata;
  logic [OUT_W-1:0]   color_c;
  logic [OUT_W-1:0]   ram [DEPTH];
  logic               unused_lum;

  // lum[0] only participates in the user-bank index when LUM_BITS is 4.
  assign unused_lum = lum[0];

  // State register and clear-sweep address.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
    end
  end

  // Next state and RAM port arbitration; a stage-1 bank-3 read owns the port.
  always_comb begin
    state_nxt = state;
    wrReady   = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = clr_addr;
    ram_wdata = USER_INIT;
    case (state)
      CLEAR: begin
        ram_we = 1'b1;
        if (clr_addr == '1) state_nxt = IDLE;
      end
      IDLE: begin
        wrReady   = !(s1_valid && (s1_bank == 2'd3));
        ram_we    = wrEn && !(s1_valid && (s1_bank == 2'd3));
        ram_waddr = wrAddr;
        ram_wdata = wrData;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  // User bank storage.
  always_ff @(posedge clk) begin
    if (ram_we && reset_n) ram[ram_waddr] <= ram_wdata;
  end

  // Bank commit on vsync rising edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vsync_q    <= 1'b0;
      activeMode <= 2'd0;
    end else begin
      vsync_q <= vsync;
      if (vsync && !vsync_q) activeMode <= mode;
    end
  end

  // Stage 1: capture index and the bank in force for this pixel.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_blank <= 1'b0;
      s1_bank  <= 2'd0;
      s1_cidx  <= '0;
      s1_addr  <= '0;
    end else begin
      s1_valid <= pixValid;
      s1_blank <= blank;
      s1_bank  <= activeMode;
      s1_cidx  <= {hue, lum[3:1]};
      s1_addr  <= {hue, lum[3 -: LUM_BITS]};
    end
  end

  // Color select; bank 3 is forced to USER_INIT until the sweep completes.
  always_comb begin
    color_c = '0;
    if (!s1_blank) begin
      case (s1_bank)
        2'd0:    color_c = scale_rgb(NTSC_TAB[s1_cidx]);
        2'd1:    color_c = scale_rgb(PAL_TAB[s1_cidx]);
        2'd2:    color_c = scale_rgb(SECAM_TAB[s1_cidx[2:0]]);
        default: color_c = (state == CLEAR) ? USER_INIT : ram[s1_addr];
      endcase
    end
  end

  // Stage 2: output register, color held across invalid cycles.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      outValid <= 1'b0;
      outColor <= '0;
    end else begin
      outValid <= s1_valid;
      if (s1_valid) outColor <= color_c;
    end
  end

endmodule
